regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/mips_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   wb_state_e    : arbiter FSM encoding (IDLE, DRAIN, CLEAR)
//   WB_DEPTH_MIN/MAX : the two legal per-requester buffer depths
//   wb_fifo_depth : maps a requested depth onto a legal one (4 stays 4,
//                   anything else falls back to 2)
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } wb_state_e;

  localparam int WB_DEPTH_MIN = 2;
  localparam int WB_DEPTH_MAX = 4;
  localparam int WB_DATA_W    = 16;

  function automatic int wb_fifo_depth(input int depth);
    if (depth == WB_DEPTH_MAX) begin
      return WB_DEPTH_MAX;
    end else begin
      return WB_DEPTH_MIN;
    end
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO used as the per-requester writeback buffer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write request and entry
//   pop          : remove the head entry (ignored when empty)
//   rdata        : current head entry (valid when !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // A push while full is still taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == {CW{1'b0}});
  assign rdata = mem_q[rd_ptr_q];

  // Entry storage: data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writebacks into the
// single register-file write port and sequences a whole-bank clear.
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data/alu_ready : ALU writeback channel
//   lsu_valid/lsu_addr/lsu_data/lsu_ready : load writeback channel
//   clear_req, clear_done              : bank clear request / completion pulse
//   req_rd, addr_rd, wdata             : registered register-file write port
//   clear                              : registered register-file clear strobe
// Configuration macro WB_ARB_RR_EN: defined -> round-robin between channels
// (ALU first after reset); undefined -> LSU always wins over ALU.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [AWIDTH-1:0] alu_addr,
  input  logic [15:0]       alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AWIDTH-1:0] lsu_addr,
  input  logic [15:0]       lsu_data,
  output logic              lsu_ready,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              req_rd,
  output logic [AWIDTH-1:0] addr_rd,
  output logic [15:0]       wdata,
  output logic              clear
);

  localparam int EW = AWIDTH + WB_DATA_W;
  localparam int FD = wb_fifo_depth(DEPTH);

  wb_state_e         state_q;
  logic              req_rd_q;
  logic [AWIDTH-1:0] addr_rd_q;
  logic [15:0]       wdata_q;
  logic              clear_q;
  logic              clear_done_q;

  logic              alu_full, alu_empty, alu_push, alu_pop;
  logic              lsu_full, lsu_empty, lsu_push, lsu_pop;
  logic [EW-1:0]     alu_head, lsu_head, issue_head;

  assign alu_ready = !alu_full && (state_q == ST_IDLE);
  assign lsu_ready = !lsu_full && (state_q == ST_IDLE);

  // Writes to register 0 complete the handshake but never enter the buffer.
  assign alu_push = alu_valid && alu_ready && (alu_addr != {AWIDTH{1'b0}});
  assign lsu_push = lsu_valid && lsu_ready && (lsu_addr != {AWIDTH{1'b0}});

  wb_fifo #(.DEPTH(FD), .WIDTH(EW)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_push),
    .wdata ({alu_addr, alu_data}),
    .pop   (alu_pop),
    .rdata (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  wb_fifo #(.DEPTH(FD), .WIDTH(EW)) u_lsu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsu_push),
    .wdata ({lsu_addr, lsu_data}),
    .pop   (lsu_pop),
    .rdata (lsu_head),
    .full  (lsu_full),
    .empty (lsu_empty)
  );

`ifdef WB_ARB_RR_EN
  // 0: ALU wins the next contention, 1: LSU wins it.
  logic rr_q;

  // Round-robin pointer flips on every contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (!alu_empty && !lsu_empty && (state_q != ST_CLEAR)) begin
      rr_q <= ~rr_q;
    end else begin
      rr_q <= rr_q;
    end
  end
`endif

  // Pick at most one FIFO head to issue this cycle; nothing issues in CLEAR.
  always_comb begin
    alu_pop = 1'b0;
    lsu_pop = 1'b0;
    if (state_q != ST_CLEAR) begin
      if (!alu_empty && !lsu_empty) begin
`ifdef WB_ARB_RR_EN
        if (rr_q) begin
          lsu_pop = 1'b1;
        end else begin
          alu_pop = 1'b1;
        end
`else
        lsu_pop = 1'b1;
`endif
      end else if (!alu_empty) begin
        alu_pop = 1'b1;
      end else if (!lsu_empty) begin
        lsu_pop = 1'b1;
      end else begin
        alu_pop = 1'b0;
      end
    end else begin
      alu_pop = 1'b0;
    end
  end

  assign issue_head = lsu_pop ? lsu_head : alu_head;

  // Arbiter FSM with registered write-port and clear outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_rd_q     <= 1'b0;
      addr_rd_q    <= {AWIDTH{1'b0}};
      wdata_q      <= 16'h0000;
      clear_q      <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      req_rd_q     <= alu_pop || lsu_pop;
      clear_q      <= 1'b0;
      clear_done_q <= 1'b0;
      if (alu_pop || lsu_pop) begin
        addr_rd_q <= issue_head[EW-1:WB_DATA_W];
        wdata_q   <= issue_head[WB_DATA_W-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_DRAIN;
          end
        end
        // Both empty implies nothing pops this cycle, so the bank is quiet.
        ST_DRAIN: begin
          if (alu_empty && lsu_empty) begin
            state_q <= ST_CLEAR;
            clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q      <= ST_IDLE;
          clear_done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rd     = req_rd_q;
  assign addr_rd    = addr_rd_q;
  assign wdata      = wdata_q;
  assign clear      = clear_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int AW = 8;
  localparam int DP = 2;

  logic          clk;
  logic          rst;
  logic          alu_valid, lsu_valid, clear_req;
  logic [AW-1:0] alu_addr, lsu_addr;
  logic [15:0]   alu_data, lsu_data;
  logic          alu_ready, lsu_ready, clear_done, req_rd, clear;
  logic [AW-1:0] addr_rd;
  logic [15:0]   wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  regfile_wb_arbiter #(.AWIDTH(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_addr   (lsu_addr),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .clear_req  (clear_req),
    .clear_done (clear_done),
    .req_rd     (req_rd),
    .addr_rd    (addr_rd),
    .wdata      (wdata),
    .clear      (clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (queues + phase) ----------------
  logic [23:0] qa[$];
  logic [23:0] ql[$];
  int          phase  = 0;   // 0 idle, 1 draining, 2 clearing
  bit          rr_lsu = 1'b0;
  logic          e_req, e_clr, e_done, e_ar, e_lr;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wd;

  logic [28:0] obs, expv;
  assign obs  = {req_rd, addr_rd, wdata, clear, clear_done, alu_ready, lsu_ready};
  assign expv = {e_req, e_addr, e_wd, e_clr, e_done, e_ar, e_lr};

  task automatic model_edge();
    bit ae, le, ra, rl;
    int pick;
    logic [23:0] ent;
    if (rst) begin
      qa.delete(); ql.delete();
      phase = 0; rr_lsu = 1'b0;
      e_req = 1'b0; e_clr = 1'b0; e_done = 1'b0;
      e_addr = 8'h00; e_wd = 16'h0000; e_ar = 1'b1; e_lr = 1'b1;
      return;
    end
    ae = (qa.size() == 0);
    le = (ql.size() == 0);
    ra = (phase == 0) && (qa.size() < DP);
    rl = (phase == 0) && (ql.size() < DP);
    pick = 0;
    if (phase != 2) begin
      if (!ae && !le) begin
`ifdef WB_ARB_RR_EN
        pick = rr_lsu ? 2 : 1;
        rr_lsu = !rr_lsu;
`else
        pick = 2;
`endif
      end else if (!ae) pick = 1;
      else if (!le) pick = 2;
    end
    e_req = (pick != 0);
    if (pick == 1) begin ent = qa.pop_front(); {e_addr, e_wd} = ent; end
    if (pick == 2) begin ent = ql.pop_front(); {e_addr, e_wd} = ent; end
    if (alu_valid && ra && alu_addr != 8'h00) qa.push_back({alu_addr, alu_data});
    if (lsu_valid && rl && lsu_addr != 8'h00) ql.push_back({lsu_addr, lsu_data});
    e_clr = 1'b0;
    e_done = 1'b0;
    if (phase == 0) begin
      if (clear_req) phase = 1;
    end else if (phase == 1) begin
      if (ae && le) begin phase = 2; e_clr = 1'b1; end
    end else begin
      phase = 0; e_done = 1'b1;
    end
    e_ar = (phase == 0) && (qa.size() < DP);
    e_lr = (phase == 0) && (ql.size() < DP);
  endtask

  // Drive one cycle of inputs, advance the model, and land on the negedge.
  task automatic tick(input logic av, input logic [7:0] aa, input logic [15:0] ad,
                      input logic lv, input logic [7:0] la, input logic [15:0] ld,
                      input logic cr);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    clear_req = cr;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    total++;
    if (obs !== expv) begin bad++; $display("FAIL reset_vec got=%h exp=%h", obs, expv); end
    total++;
    if ({req_rd, addr_rd, wdata, clear, clear_done, alu_ready, lsu_ready} !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL reset_const got=%h exp=%h", obs, {1'b0, 8'h00, 16'h0000, 4'b0011});
    end
  endtask

  task automatic test_single();
    logic [2:0] rq;
    tick(1'b1, 8'd5, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0);
    rq[0] = req_rd;
    idle();
    total++;
    if ({req_rd, addr_rd, wdata} !== {1'b1, 8'd5, 16'h1234}) begin
      bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/1234", req_rd, addr_rd, wdata);
    end
    rq[1] = req_rd;
    idle();
    rq[2] = req_rd;
    total++;
    if (rq !== 3'b010) begin bad++; $display("FAIL single_pulse got=%b exp=010", rq); end
    total++;
    if ({addr_rd, wdata} !== {8'd5, 16'h1234}) begin
      bad++; $display("FAIL single_hold got=%0d/%h exp=5/1234", addr_rd, wdata);
    end
  endtask

  task automatic test_zero_reg();
    int pulses = 0;
    total++;
    if (alu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", alu_ready); end
    tick(1'b1, 8'd0, 16'hFFFF, 1'b0, 8'h00, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (req_rd) pulses++;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL zero_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      idle();
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL zero_no_write got=%0d exp=0", pulses); end
  endtask

  task automatic test_contention();
    logic [17:0] got, want;
    rst = 1'b1; idle(); rst = 1'b0;
    tick(1'b1, 8'd3, 16'hAAAA, 1'b1, 8'd4, 16'hBBBB, 1'b0);
    idle();
    got[17:9] = {req_rd, addr_rd};
    total++;
    if (obs !== expv) begin bad++; $display("FAIL contention_vec1 got=%h exp=%h", obs, expv); end
    idle();
    got[8:0] = {req_rd, addr_rd};
    total++;
    if (obs !== expv) begin bad++; $display("FAIL contention_vec2 got=%h exp=%h", obs, expv); end
`ifdef WB_ARB_RR_EN
    want = {1'b1, 8'd3, 1'b1, 8'd4};
`else
    want = {1'b1, 8'd4, 1'b1, 8'd3};
`endif
    total++;
    if (got !== want) begin bad++; $display("FAIL contention_order got=%h exp=%h", got, want); end
    idle();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int cur;
    int got[$];
    for (int c = 0; c < 20 && acc < 4; c++) begin
      cur = acc;
      if (e_lr) acc++;
      tick(1'b1, 8'(8'h10 + c), 16'(16'hA000 + c), 1'b1, 8'(8'h40 + cur), 16'(16'hC000 + cur), 1'b0);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL bp_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (req_rd && addr_rd[7:4] == 4'h4) got.push_back(int'(addr_rd));
    end
    for (int c = 0; c < 12; c++) begin
      idle();
      total++;
      if (obs !== expv) begin bad++; $display("FAIL bp_drain_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (req_rd && addr_rd[7:4] == 4'h4) got.push_back(int'(addr_rd));
    end
    total++;
    if (got.size() != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] != 8'h40 + i) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], 8'h40 + i); end
    end
  endtask

  task automatic test_clear();
    int nwr = 0, nclr = 0, clr_at = -1, done_at = -1;
    bit rdy_bad = 1'b0;
    tick(1'b1, 8'd6, 16'h0606, 1'b1, 8'd7, 16'h0707, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, (c == 0));
      total++;
      if (obs !== expv) begin bad++; $display("FAIL clear_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (req_rd) nwr++;
      if (clear) begin nclr++; clr_at = c; if (nwr != 2 || req_rd) rdy_bad = 1'b1; end
      if (clear_done && done_at < 0) done_at = c;
      if (done_at < 0 && (alu_ready || lsu_ready)) rdy_bad = 1'b1;
    end
    total++;
    if (nwr != 2 || nclr != 1) begin bad++; $display("FAIL clear_counts got=%0d/%0d exp=2/1", nwr, nclr); end
    total++;
    if (clr_at < 0 || done_at != clr_at + 1) begin bad++; $display("FAIL clear_done_timing got=%0d exp=%0d", done_at, clr_at + 1); end
    total++;
    if (rdy_bad) begin bad++; $display("FAIL clear_ready_low got=1 exp=0"); end
  endtask

  task automatic test_reset_drain();
    int seen = 0;
    tick(1'b1, 8'd9, 16'h0909, 1'b1, 8'd10, 16'h0A0A, 1'b0);
    tick(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    total++;
    if ({clear, clear_done, alu_ready, lsu_ready, req_rd} !== 5'b00110) begin
      bad++; $display("FAIL rstdrain_state got=%b exp=00110", {clear, clear_done, alu_ready, lsu_ready, req_rd});
    end
    for (int c = 0; c < 5; c++) begin
      idle();
      if (req_rd || clear || clear_done) seen++;
      total++;
      if (obs !== expv) begin bad++; $display("FAIL rstdrain_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rstdrain_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    logic [7:0] aa, la;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      aa = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      la = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      tick(1'($urandom_range(0, 1)), aa, 16'($urandom), 1'($urandom_range(0, 1)), la, 16'($urandom),
           ($urandom_range(0, 24) == 0));
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = 8'h00; alu_data = 16'h0000;
    lsu_valid = 1'b0; lsu_addr = 8'h00; lsu_data = 16'h0000;
    clear_req = 1'b0;
    test_reset();
    test_single();
    test_zero_reg();
    test_contention();
    test_backpressure();
    test_clear();
    test_reset_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
